// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row drive, 2-FF column synchroniser,
// lowest-index key selection per scan and scan-level debounce of the key code.
module keypad_scanner #(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       CLOCK_25,
    input  logic       reset,
    output logic [3:0] rows,
    input  logic [3:0] cols,
    output logic [3:0] keys,
    output logic       key_pressed,
    output logic       key_event
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       cols_p0, cols_p1;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic             scan_found;
    logic [3:0]       scan_code;
    logic             prev_found;
    logic [3:0]       prev_code;
    logic [CNT_W-1:0] stab_cnt;

    logic             last_div;
    logic [2:0]       row_sel;
    logic             cand_found;
    logic [3:0]       cand_code;
    logic [CNT_W-1:0] cnt_next;
    logic             out_differs;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'd0:  k = 4'h1;
            4'd1:  k = 4'h2;
            4'd2:  k = 4'h3;
            4'd3:  k = 4'hA;
            4'd4:  k = 4'h4;
            4'd5:  k = 4'h5;
            4'd6:  k = 4'h6;
            4'd7:  k = 4'hB;
            4'd8:  k = 4'h7;
            4'd9:  k = 4'h8;
            4'd10: k = 4'h9;
            4'd11: k = 4'hC;
            4'd12: k = 4'hE;
            4'd13: k = 4'h0;
            4'd14: k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Returns {hit, column} for the lowest-numbered low column.
    function automatic logic [2:0] lowest_col(input logic [3:0] c_n);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (!c_n[i]) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + CNT_ONE;
    endfunction

    always_comb begin
        last_div    = (div_cnt == DIV_LAST);
        row_sel     = lowest_col(cols_p1);
        cand_found  = scan_found | row_sel[2];
        cand_code   = 4'h0;
        if (scan_found)      cand_code = scan_code;
        else if (row_sel[2]) cand_code = key_code(row_idx, row_sel[1:0]);
        cnt_next    = ({cand_found, cand_code} == {prev_found, prev_code}) ? sat_inc(stab_cnt) : CNT_ONE;
        out_differs = ({cand_found, cand_code} != {key_pressed, keys});
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            cols_p0     <= 4'hF;
            cols_p1     <= 4'hF;
            div_cnt     <= '0;
            row_idx     <= 2'd0;
            rows        <= 4'b1110;
            scan_found  <= 1'b0;
            scan_code   <= 4'h0;
            prev_found  <= 1'b0;
            prev_code   <= 4'h0;
            stab_cnt    <= '0;
            keys        <= 4'h0;
            key_pressed <= 1'b0;
            key_event   <= 1'b0;
        end else begin
            // synchroniser stage
            cols_p0   <= cols;
            cols_p1   <= cols_p0;
            key_event <= 1'b0;
            // scan / debounce stage
            if (last_div) begin
                div_cnt <= '0;
                row_idx <= row_idx + 2'd1;
                rows    <= ~(4'b0001 << (row_idx + 2'd1));
                if (row_idx == 2'd3) begin
                    scan_found <= 1'b0;
                    scan_code  <= 4'h0;
                    prev_found <= cand_found;
                    prev_code  <= cand_code;
                    stab_cnt   <= cnt_next;
                    if (cnt_next == CNT_MAX && out_differs) begin
                        key_pressed <= cand_found;
                        keys        <= cand_code;
                        key_event   <= cand_found;
                    end
                end else begin
                    scan_found <= cand_found;
                    scan_code  <= cand_code;
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule
